// File: rtl/trig_route_pkg.sv
// Shared encodings for the trigger router: source-combine modes and FSM states.
// The HOLDOFF state only exists when TRIG_ROUTE_HOLDOFF_EN is defined.
package trig_route_pkg;

   localparam logic [1:0] MODE_OR_LVL   = 2'd0;
   localparam logic [1:0] MODE_OR_EDGE  = 2'd1;
   localparam logic [1:0] MODE_AND_LVL  = 2'd2;
   localparam logic [1:0] MODE_AND_EDGE = 2'd3;

`ifdef TRIG_ROUTE_HOLDOFF_EN
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FIRE    = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1
   } state_t;
`endif

   // Mode bit 0 selects edge behaviour, bit 1 selects the AND reduction.
   function automatic logic mode_is_edge(input logic [1:0] mode);
      return (mode == MODE_OR_EDGE) || (mode == MODE_AND_EDGE);
   endfunction

   function automatic logic mode_is_and(input logic [1:0] mode);
      return (mode == MODE_AND_LVL) || (mode == MODE_AND_EDGE);
   endfunction

endpackage

// File: rtl/trig_route_combine.sv
// Masks the trigger sources, forms the OR and AND reductions and detects rising
// edges of each against a register that resets high (no fire right after reset).
module trig_route_combine
   import trig_route_pkg::*;
#(
   parameter int pSOURCES = 4
) (
   input  logic                fe_clk,
   input  logic                reset,
   input  logic [pSOURCES-1:0] I_src,
   input  logic [pSOURCES-1:0] I_enable,
   input  logic [1:0]          I_mode,
   output logic                O_or_val,
   output logic                O_and_val,
   output logic                O_event
);

   logic or_val;
   logic and_val;
   logic or_edge;
   logic and_edge;
   logic or_prev_q, or_prev_d;
   logic and_prev_q, and_prev_d;

   always_comb begin
      or_val     = |(I_src & I_enable);
      // An empty mask would make the AND reduction vacuously true; force it low.
      and_val    = (|I_enable) & (&(I_src | ~I_enable));
      or_edge    = or_val & ~or_prev_q;
      and_edge   = and_val & ~and_prev_q;
      or_prev_d  = or_val;
      and_prev_d = and_val;
   end

   always_comb begin
      O_event = 1'b0;
      case (I_mode)
         MODE_OR_LVL:   O_event = or_val;
         MODE_OR_EDGE:  O_event = or_edge;
         MODE_AND_LVL:  O_event = and_val;
         MODE_AND_EDGE: O_event = and_edge;
         default:       O_event = 1'b0;
      endcase
   end

   always_ff @(posedge fe_clk or posedge reset) begin
      if (reset) begin
         or_prev_q  <= 1'b1;
         and_prev_q <= 1'b1;
      end else begin
         or_prev_q  <= or_prev_d;
         and_prev_q <= and_prev_d;
      end
   end

   assign O_or_val  = or_val;
   assign O_and_val = and_val;

endmodule

// File: rtl/trig_route_ctrl.sv
// Trigger router: combines masked sources, fires a registered trigger pulse, counts fires.
// Optional post-fire dead time is built only when TRIG_ROUTE_HOLDOFF_EN is defined.
module trig_route_ctrl
   import trig_route_pkg::*;
#(
   parameter int pSOURCES       = 4,
   parameter int pSTRETCH_WIDTH = 8,
   parameter int pHOLDOFF_WIDTH = 16,
   parameter int pCOUNT_WIDTH   = 16,
   parameter int pLED_BIT       = 22
) (
   input  logic                      fe_clk,
   input  logic                      reset,
   input  logic [pSOURCES-1:0]       I_src,
   input  logic [pSOURCES-1:0]       I_enable,
   input  logic [1:0]                I_mode,
   input  logic                      I_arm,
   input  logic                      I_oneshot,
   input  logic [pSTRETCH_WIDTH-1:0] I_stretch,
   input  logic [pHOLDOFF_WIDTH-1:0] I_holdoff,
   input  logic                      I_clear_count,
   output logic                      O_trig,
   output logic                      O_busy,
   output logic [pCOUNT_WIDTH-1:0]   O_trig_count,
   output logic                      O_led_alive,
   output logic [1:0]                O_dbg_state
);

   localparam logic [pSTRETCH_WIDTH-1:0] STRETCH_ONE = {{(pSTRETCH_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [pCOUNT_WIDTH-1:0]   COUNT_ONE   = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [pLED_BIT:0]         ACT_ONE     = {{pLED_BIT{1'b0}}, 1'b1};

   logic or_val;
   logic and_val;
   logic evt;
   logic level_val;
   logic fire_done;
   logic fire;

   state_t                    state_q, state_d;
   logic                      trig_q, trig_d;
   logic [1:0]                mode_q, mode_d;
   logic [pSTRETCH_WIDTH-1:0] stretch_q, stretch_d;
   logic                      spent_q, spent_d;
   logic [pCOUNT_WIDTH-1:0]   count_q, count_d;
   logic [pLED_BIT:0]         act_q, act_d;

`ifdef TRIG_ROUTE_HOLDOFF_EN
   localparam logic [pHOLDOFF_WIDTH-1:0] HOLD_ONE = {{(pHOLDOFF_WIDTH-1){1'b0}}, 1'b1};
   logic [pHOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;
`else
   logic unused_holdoff;
   assign unused_holdoff = ^I_holdoff;
`endif

   trig_route_combine #(
      .pSOURCES (pSOURCES)
   ) u_combine (
      .fe_clk    (fe_clk),
      .reset     (reset),
      .I_src     (I_src),
      .I_enable  (I_enable),
      .I_mode    (I_mode),
      .O_or_val  (or_val),
      .O_and_val (and_val),
      .O_event   (evt)
   );

   // FIRE decisions use the mode latched at entry, never the live I_mode.
   always_comb begin
      level_val = mode_is_and(mode_q) ? and_val : or_val;
      fire_done = mode_is_edge(mode_q) ? (stretch_q <= STRETCH_ONE) : ~level_val;
   end

   always_comb begin
      state_d   = state_q;
      trig_d    = trig_q;
      mode_d    = mode_q;
      stretch_d = stretch_q;
      fire      = 1'b0;
`ifdef TRIG_ROUTE_HOLDOFF_EN
      holdoff_d = holdoff_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (I_arm && evt && !spent_q) begin
               fire      = 1'b1;
               state_d   = ST_FIRE;
               trig_d    = 1'b1;
               mode_d    = I_mode;
               stretch_d = (I_stretch == '0) ? STRETCH_ONE : I_stretch;
            end
         end
         ST_FIRE: begin
            if (!I_arm) begin
               // Disarm aborts the pulse outright and skips any dead time.
               state_d = ST_IDLE;
               trig_d  = 1'b0;
            end else if (fire_done) begin
               trig_d = 1'b0;
`ifdef TRIG_ROUTE_HOLDOFF_EN
               if (I_holdoff != '0) begin
                  state_d   = ST_HOLDOFF;
                  holdoff_d = I_holdoff;
               end else begin
                  state_d = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end else if (mode_is_edge(mode_q)) begin
               stretch_d = stretch_q - STRETCH_ONE;
            end
         end
`ifdef TRIG_ROUTE_HOLDOFF_EN
         ST_HOLDOFF: begin
            if (holdoff_q <= HOLD_ONE) begin
               state_d = ST_IDLE;
            end else begin
               holdoff_d = holdoff_q - HOLD_ONE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (I_clear_count) begin
         count_d = '0;
      end else if (fire && (count_q != '1)) begin
         count_d = count_q + COUNT_ONE;
      end

      spent_d = spent_q;
      if (!I_arm) begin
         spent_d = 1'b0;
      end else if (fire && I_oneshot) begin
         spent_d = 1'b1;
      end

      // Activity counter pauses while the trigger is high.
      act_d = trig_q ? act_q : (act_q + ACT_ONE);
   end

   always_ff @(posedge fe_clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         trig_q    <= 1'b0;
         mode_q    <= MODE_OR_LVL;
         stretch_q <= '0;
         spent_q   <= 1'b0;
         count_q   <= '0;
         act_q     <= '0;
`ifdef TRIG_ROUTE_HOLDOFF_EN
         holdoff_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         trig_q    <= trig_d;
         mode_q    <= mode_d;
         stretch_q <= stretch_d;
         spent_q   <= spent_d;
         count_q   <= count_d;
         act_q     <= act_d;
`ifdef TRIG_ROUTE_HOLDOFF_EN
         holdoff_q <= holdoff_d;
`endif
      end
   end

   assign O_trig       = trig_q;
   assign O_trig_count = count_q;
   assign O_led_alive  = act_q[pLED_BIT];
   assign O_dbg_state  = state_q;
`ifdef TRIG_ROUTE_HOLDOFF_EN
   assign O_busy = (state_q != ST_IDLE);
`else
   assign O_busy = (state_q == ST_FIRE);
`endif

endmodule

// File: tb/tb_trig_route_ctrl.sv
// Self-checking bench for trig_route_ctrl: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model of the trigger rules.
module tb_trig_route_ctrl;
   import trig_route_pkg::*;

   localparam int NSRC = 4;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic          fe_clk = 1'b0;
   logic          reset;
   logic [3:0]    I_src;
   logic [3:0]    I_enable;
   logic [1:0]    I_mode;
   logic          I_arm;
   logic          I_oneshot;
   logic [7:0]    I_stretch;
   logic [15:0]   I_holdoff;
   logic          I_clear_count;
   logic          O_trig;
   logic          O_busy;
   logic [CW-1:0] O_trig_count;
   logic          O_led_alive;
   logic [1:0]    O_dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];

   always #5 fe_clk = ~fe_clk;

   trig_route_ctrl #(
      .pSOURCES       (NSRC),
      .pSTRETCH_WIDTH (8),
      .pHOLDOFF_WIDTH (16),
      .pCOUNT_WIDTH   (CW),
      .pLED_BIT       (0)
   ) dut (
      .fe_clk        (fe_clk),
      .reset         (reset),
      .I_src         (I_src),
      .I_enable      (I_enable),
      .I_mode        (I_mode),
      .I_arm         (I_arm),
      .I_oneshot     (I_oneshot),
      .I_stretch     (I_stretch),
      .I_holdoff     (I_holdoff),
      .I_clear_count (I_clear_count),
      .O_trig        (O_trig),
      .O_busy        (O_busy),
      .O_trig_count  (O_trig_count),
      .O_led_alive   (O_led_alive),
      .O_dbg_state   (O_dbg_state)
   );

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Expected trigger output, remaining pulse length, remaining dead cycles, etc.
   bit m_trig, m_edge, m_and, m_spent, m_prev_or, m_prev_and;
   int m_left, m_hold, m_count, m_act;

   task automatic model_reset();
      m_trig = 0; m_edge = 0; m_and = 0; m_spent = 0;
      m_prev_or = 1; m_prev_and = 1;
      m_left = 0; m_hold = 0; m_count = 0; m_act = 0;
   endtask

   task automatic model_step();
      bit or_v, and_v, ev, sel, fire;
      or_v  = 0;
      and_v = (I_enable != 4'd0);
      for (int i = 0; i < NSRC; i++) begin
         if (I_enable[i] && I_src[i])  or_v  = 1;
         if (I_enable[i] && !I_src[i]) and_v = 0;
      end
      case (I_mode)
         2'd0:    ev = or_v;
         2'd1:    ev = or_v && !m_prev_or;
         2'd2:    ev = and_v;
         default: ev = and_v && !m_prev_and;
      endcase
      fire = 0;
      if (!m_trig) m_act++;
      if (m_trig) begin
         if (!I_arm) begin
            m_trig = 0;
         end else begin
            sel = m_and ? and_v : or_v;
            if (m_edge ? (m_left <= 1) : !sel) begin
               m_trig = 0;
`ifdef TRIG_ROUTE_HOLDOFF_EN
               m_hold = int'(I_holdoff);
`endif
            end else begin
               m_left--;
            end
         end
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (I_arm && ev && !m_spent) begin
         fire   = 1;
         m_trig = 1;
         m_edge = (I_mode == 2'd1) || (I_mode == 2'd3);
         m_and  = (I_mode == 2'd2) || (I_mode == 2'd3);
         m_left = (I_stretch == 8'd0) ? 1 : int'(I_stretch);
      end
      if (I_clear_count) m_count = 0;
      else if (fire && m_count < CMAX) m_count++;
      if (!I_arm) m_spent = 0;
      else if (fire && I_oneshot) m_spent = 1;
      m_prev_or  = or_v;
      m_prev_and = and_v;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      model_step();
      @(posedge fe_clk);
      #1;
      check("trig", O_trig, m_trig);
      check("busy", O_busy, m_trig || (m_hold > 0));
      check("count", O_trig_count, m_count);
      check("led", O_led_alive, m_act % 2);
   endtask

   task automatic settle();
      int n;
      n = 0;
      I_src = 4'd0; I_arm = 0; I_oneshot = 0; I_clear_count = 0;
      cycle();
      while (O_busy && n < 100) begin
         cycle();
         n++;
      end
      check("settle_idle", O_busy, 0);
   endtask

   task automatic clear_cnt();
      I_clear_count = 1;
      cycle();
      I_clear_count = 0;
      check("clear_count", O_trig_count, 0);
   endtask

   initial begin
      #300000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- test ----------------
   typedef struct {
      logic [1:0] mode;
      logic [3:0] en;
      logic [3:0] src;
      logic       exp_fire;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int n;
      int n_exp_fires;
      logic prev;

      vecs[0]  = '{2'd0, 4'b0011, 4'b0010, 1'b1};
      vecs[1]  = '{2'd0, 4'b0011, 4'b1100, 1'b0};
      vecs[2]  = '{2'd0, 4'b0000, 4'b1111, 1'b0};
      vecs[3]  = '{2'd2, 4'b0101, 4'b0101, 1'b1};
      vecs[4]  = '{2'd2, 4'b0101, 4'b0100, 1'b0};
      vecs[5]  = '{2'd2, 4'b0000, 4'b1111, 1'b0};
      vecs[6]  = '{2'd2, 4'b1000, 4'b1001, 1'b1};
      vecs[7]  = '{2'd2, 4'b1010, 4'b0111, 1'b0};
      vecs[8]  = '{2'd1, 4'b0011, 4'b0001, 1'b1};
      vecs[9]  = '{2'd3, 4'b1100, 4'b1100, 1'b1};
      vecs[10] = '{2'd3, 4'b1100, 4'b0100, 1'b0};
      vecs[11] = '{2'd1, 4'b0000, 4'b1111, 1'b0};
      vecs[12] = '{2'd3, 4'b1111, 4'b1111, 1'b1};

      // Reset with sources already high and armed in an edge mode.
      reset = 1;
      I_src = 4'b1111; I_enable = 4'b1111; I_mode = 2'd1; I_arm = 1;
      I_oneshot = 0; I_stretch = 8'd1; I_holdoff = 16'd0; I_clear_count = 0;
      model_reset();
      repeat (2) @(posedge fe_clk);
      #1;
      check("rst_trig", O_trig, 0);
      check("rst_busy", O_busy, 0);
      check("rst_count", O_trig_count, 0);
      check("rst_led", O_led_alive, 0);
      check("rst_state", O_dbg_state, ST_IDLE);
      reset = 0;
      cycle();
      check("no_fire_after_reset", O_trig, 0);

      // Table-driven combine vectors, each from a quiet IDLE.
      for (int i = 0; i < 13; i++) begin
         settle();
         I_stretch = 8'd1; I_holdoff = 16'd0;
         I_mode = vecs[i].mode; I_enable = vecs[i].en; I_src = vecs[i].src; I_arm = 1;
         cycle();
         check($sformatf("vec%0d_fire", i), O_trig, vecs[i].exp_fire);
      end

      // OR-edge, stretch 5; stretch change mid-pulse must not matter.
      settle(); clear_cnt();
      I_mode = 2'd1; I_enable = 4'b0011; I_stretch = 8'd5; I_holdoff = 16'd0; I_arm = 1;
      cycle();
      I_src = 4'b0010;
      cycle();
      check("edge_latency", O_trig, 1);
      I_src = 4'b0000; I_stretch = 8'd2;
      n = 1;
      repeat (8) begin
         cycle();
         n += int'(O_trig);
      end
      check("stretch5_len", n, 5);
      check("stretch5_count", O_trig_count, 1);

      // AND-level held 7 cycles; mode change during FIRE ignored.
      settle(); clear_cnt();
      I_mode = 2'd2; I_enable = 4'b0101; I_holdoff = 16'd0; I_arm = 1; I_src = 4'b0101;
      n = 0;
      for (int i = 0; i < 7; i++) begin
         cycle();
         n += int'(O_trig);
         if (i == 1) I_mode = 2'd0;
      end
      I_src = 4'b0100; I_mode = 2'd2;
      cycle();
      check("and_level_len", n, 7);
      check("and_level_drop", O_trig, 0);
      n = 0;
      repeat (5) begin
         cycle();
         n += int'(O_trig);
      end
      check("and_partial_nofire", n, 0);
      check("and_level_count", O_trig_count, 1);

      // Edges every 4 cycles with holdoff 10, stretch 1.
      settle(); clear_cnt();
      I_mode = 2'd1; I_enable = 4'b0001; I_stretch = 8'd1; I_holdoff = 16'd10; I_arm = 1;
      cycle();
      exp_q.delete();
`ifdef TRIG_ROUTE_HOLDOFF_EN
      for (int c = 0; c < 40; c += 12) exp_q.push_back(8'(c));
`else
      for (int c = 0; c < 40; c += 4) exp_q.push_back(8'(c));
`endif
      n_exp_fires = exp_q.size();
      for (int c = 0; c < 40; c++) begin
         I_src = (c % 4 == 0) ? 4'b0001 : 4'b0000;
         prev = O_trig;
         cycle();
         if (O_trig && !prev) begin
            if (exp_q.size() == 0) check("holdoff_extra_fire", c, 255);
            else check("holdoff_fire_cycle", c, exp_q.pop_front());
         end
      end
      check("holdoff_missing_fires", exp_q.size(), 0);
      check("holdoff_count", O_trig_count, n_exp_fires);

      // One-shot: three edges give one fire until re-armed.
      settle(); clear_cnt();
      I_mode = 2'd1; I_enable = 4'b0001; I_stretch = 8'd1; I_holdoff = 16'd0;
      I_oneshot = 1; I_arm = 1;
      cycle();
      n = 0;
      for (int c = 0; c < 12; c++) begin
         I_src = (c % 4 == 0) ? 4'b0001 : 4'b0000;
         cycle();
         n += int'(O_trig);
      end
      check("oneshot_single", n, 1);
      I_arm = 0; I_src = 4'b0000;
      cycle();
      I_arm = 1;
      cycle();
      n = 0;
      for (int c = 0; c < 4; c++) begin
         I_src = (c == 0) ? 4'b0001 : 4'b0000;
         cycle();
         n += int'(O_trig);
      end
      check("oneshot_rearm", n, 1);
      check("oneshot_count", O_trig_count, 2);

      // Counter saturation, then clear coincident with a fire.
      settle(); clear_cnt();
      I_mode = 2'd1; I_enable = 4'b0001; I_stretch = 8'd1; I_holdoff = 16'd0; I_arm = 1;
      cycle();
      for (int k = 0; k < 20; k++) begin
         I_src = 4'b0001; cycle();
         I_src = 4'b0000; cycle();
      end
      check("count_sat", O_trig_count, 15);
      I_src = 4'b0001; I_clear_count = 1;
      cycle();
      check("clear_vs_fire_count", O_trig_count, 0);
      check("clear_vs_fire_trig", O_trig, 1);
      I_clear_count = 0; I_src = 4'b0000;
      cycle();
      I_src = 4'b0001;
      cycle();
      check("count_after_clear", O_trig_count, 1);

      // Reset in the middle of a long pulse.
      settle();
      I_mode = 2'd1; I_enable = 4'b0001; I_stretch = 8'd20; I_holdoff = 16'd0; I_arm = 1;
      cycle();
      I_src = 4'b0001; cycle();
      I_src = 4'b0000; cycle(); cycle();
      check("pre_reset_trig", O_trig, 1);
      #2 reset = 1;
      #1;
      check("midfire_rst_trig", O_trig, 0);
      check("midfire_rst_busy", O_busy, 0);
      check("midfire_rst_state", O_dbg_state, ST_IDLE);
      check("midfire_rst_led", O_led_alive, 0);
      check("midfire_rst_count", O_trig_count, 0);
      model_reset();
      @(posedge fe_clk);
      #1 reset = 0;
      cycle();
      check("led_restart", O_led_alive, 1);

      // Randomized traffic against the model.
      settle();
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 1) == 0) I_src = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) I_enable = 4'($urandom_range(0, 15));
         I_mode        = 2'($urandom_range(0, 3));
         I_arm         = ($urandom_range(0, 9) != 0);
         I_oneshot     = ($urandom_range(0, 3) == 0);
         I_stretch     = 8'($urandom_range(0, 4));
         I_holdoff     = 16'($urandom_range(0, 3));
         I_clear_count = ($urandom_range(0, 19) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trig_route_ctrl.md
TRIG_ROUTE_CTRL -- requirements
Module: trig_route_ctrl

Interface
REQ-001 SHALL have parameter pSOURCES, default 4: number of trigger source inputs.
REQ-002 SHALL have parameter pSTRETCH_WIDTH, default 8: width of the pulse-stretch setting.
REQ-003 SHALL have parameter pHOLDOFF_WIDTH, default 16: width of the holdoff setting.
REQ-004 SHALL have parameter pCOUNT_WIDTH, default 16: width of the trigger counter.
REQ-005 SHALL have parameter pLED_BIT, default 22: bit of the activity counter driven to O_led_alive.
REQ-006 SHALL have port fe_clk, input, 1 bit: the only clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port I_src, input, [pSOURCES-1:0]: trigger sources, already synchronous to fe_clk.
REQ-009 SHALL have port I_enable, input, [pSOURCES-1:0]: per-source enable mask.
REQ-010 SHALL have port I_mode, input, [1:0]: 0 = OR-level, 1 = OR-edge, 2 = AND-level, 3 = AND-edge.
REQ-011 SHALL have port I_arm, input, 1 bit: the block may fire only while this is high.
REQ-012 SHALL have port I_oneshot, input, 1 bit: allow one fire per I_arm high period.
REQ-013 SHALL have port I_stretch, input, [pSTRETCH_WIDTH-1:0]: O_trig pulse length in edge modes.
REQ-014 SHALL have port I_holdoff, input, [pHOLDOFF_WIDTH-1:0]: dead cycles after each fire.
REQ-015 SHALL have port I_clear_count, input, 1 bit: synchronous clear of the trigger counter.
REQ-016 SHALL have port O_trig, output, 1 bit: registered trigger output.
REQ-017 SHALL have port O_busy, output, 1 bit: high in FIRE or HOLDOFF.
REQ-018 SHALL have port O_trig_count, output, [pCOUNT_WIDTH-1:0]: saturating count of fires.
REQ-019 SHALL have port O_led_alive, output, 1 bit: clock-alive indicator.

Function
REQ-020 OR-combine SHALL be |(I_src & I_enable); AND-combine SHALL be &(I_src | ~I_enable) and is forced to 0 when I_enable is all zeros.
REQ-021 Edge modes SHALL fire on a 0->1 transition of the combined value relative to its previous-cycle register; that register resets to 1, so no fire occurs on the first cycle after reset.
REQ-022 FSM SHALL have the states IDLE, FIRE and HOLDOFF, and reset to IDLE.
REQ-023 IDLE->FIRE SHALL occur when I_arm=1, the event is true and the block is not spent; O_trig SHALL be 1 in the following cycle (1-cycle latency).
REQ-024 I_mode and I_stretch SHALL be latched on IDLE->FIRE; changes to them during FIRE or HOLDOFF SHALL be ignored.
REQ-025 FIRE in edge modes SHALL last max(I_stretch,1) cycles; I_stretch=0 SHALL behave as 1.
REQ-026 FIRE in level modes SHALL persist while the combined value stays 1 and SHALL exit the cycle after it drops.
REQ-027 On FIRE exit, the FSM SHALL go to HOLDOFF if I_holdoff>0 (see REQ-036), else to IDLE.
REQ-028 HOLDOFF SHALL hold O_trig=0, ignore all events for exactly I_holdoff cycles, then return to IDLE.
REQ-029 I_arm=0 during FIRE SHALL force O_trig=0 and IDLE on the next cycle, with no holdoff.
REQ-030 With I_oneshot=1, the spent flag SHALL set on fire and clear only when I_arm=0.
REQ-031 O_trig_count SHALL increment on each IDLE->FIRE transition and saturate at all-ones.
REQ-032 I_clear_count SHALL take precedence over a simultaneous increment, giving a count of 0.
REQ-033 A free-running activity counter SHALL increment when O_trig=0 and freeze while O_trig=1 to reduce noise; O_led_alive SHALL equal counter[pLED_BIT].

Reset
REQ-034 On reset assertion, all registers SHALL clear immediately: O_trig=0, O_busy=0, O_trig_count=0, activity counter=0, spent flag=0, state=IDLE.
REQ-035 Reset during FIRE or HOLDOFF SHALL abort to IDLE without a counter update.

Configuration
REQ-036 Macro TRIG_ROUTE_HOLDOFF_EN SHALL control the holdoff feature:
- defined: HOLDOFF state and counter present, behaviour per REQ-027/028.
- undefined: HOLDOFF state absent, FIRE exits straight to IDLE, I_holdoff ignored, O_busy equals (state==FIRE).

Structure
REQ-037 Package trig_route_pkg SHALL hold the mode encodings (MODE_OR_LVL, MODE_OR_EDGE, MODE_AND_LVL, MODE_AND_EDGE) and the FSM state typedef.
REQ-038 Sub-module trig_route_combine SHALL perform masking, OR/AND reduction and edge detection, and expose the event signal.

Verification
REQ-039 Bench SHALL cover: mode=1, enable=4'b0011, I_stretch=5, pulse I_src[1] -> O_trig high exactly 5 cycles starting 1 cycle later; count=1.
REQ-040 Bench SHALL cover: mode=2, enable=4'b0101, I_src=4'b0101 for 7 cycles -> O_trig high 7 cycles; I_src=4'b0100 -> no fire.
REQ-041 Bench SHALL cover: with TRIG_ROUTE_HOLDOFF_EN, I_holdoff=10, edges every 4 cycles -> fires spaced 1+stretch+10 cycles; without the macro -> fires on every edge.
REQ-042 Bench SHALL cover: I_oneshot=1, 3 edges with I_arm held -> 1 fire; drop and raise I_arm -> next edge fires.
REQ-043 Bench SHALL cover: count preset to all-ones via repeated fires (pCOUNT_WIDTH=4) -> holds 15; clear coincident with a fire -> 0.
REQ-044 Bench SHALL cover: reset asserted mid-FIRE -> O_trig=0 within the same cycle, state IDLE, activity counter 0.
